// File: rtl/ar4_seq_ctrl.sv
// Sequencer for a radix-4 multiplier datapath.
// Four active-low buttons are synchronized and edge-detected into one-cycle
// commands. The FSM collects operand bytes, clears the product register, runs
// N/2 add-and-shift steps, then pages the product out 16 bits at a time.
//
// Handshake/strobe semantics: every command (cmd*) and every datapath strobe
// (ldA, ldX, initP, shEn, lastStep, dispEn) is a single-cycle pulse that the
// datapath acts on at the rising edge closing that cycle; there is no
// back-pressure. readyAR4 is a level that stays high for the whole DONE state.
module ar4_seq_ctrl #(
    parameter  int N  = 16,
    localparam int NB = N / 8,
    localparam int NS = N / 2,
    localparam int PW = $clog2(N / 8)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          startAR4,
    input  logic          getA,
    input  logic          getX,
    input  logic          putOut,
    output logic [NB-1:0] ldA,
    output logic [NB-1:0] ldX,
    output logic          initP,
    output logic          shEn,
    output logic          lastStep,
    output logic          readyAR4,
    output logic          dispEn,
    output logic [PW-1:0] outPage,
    output logic [2:0]    dbgState
);

    // Byte counters must reach NB itself, step counter only NS-1.
    localparam int CW = $clog2(NB + 1);
    localparam int SW = $clog2(NS);
    localparam logic [CW-1:0] nbCnt    = CW'(NB);
    localparam logic [SW-1:0] stepLast = SW'(NS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        INIT = 3'd2,
        CALC = 3'd3,
        DONE = 3'd4
    } stateT;

    // ------------------------------------------------------------------
    // Button synchronizers and falling-edge detectors.
    // Bit order: 0 = startAR4, 1 = getA, 2 = getX, 3 = putOut.
    // ------------------------------------------------------------------
    logic [3:0] btnRaw;
    logic [3:0] syncA;
    logic [3:0] syncB;
    logic [3:0] prevB;
    logic [3:0] armed;
    logic [1:0] syncValid;
    logic [3:0] cmd;

    assign btnRaw = {putOut, getX, getA, startAR4};

    // Two-flop synchronizer plus previous-value flop. A button only becomes
    // armed once it has been seen released after reset (syncValid marks the
    // point where syncB holds real samples rather than reset values), so a
    // button held through reset cannot fire until released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncA     <= '1;
            syncB     <= '1;
            prevB     <= '1;
            armed     <= '0;
            syncValid <= '0;
        end else begin
            syncA     <= btnRaw;
            syncB     <= syncA;
            prevB     <= syncB;
            syncValid <= {syncValid[0], 1'b1};
            armed     <= armed | (syncB & {4{syncValid[1]}});
        end
    end

    assign cmd = armed & prevB & ~syncB;

    logic cmdStart;
    logic cmdA;
    logic cmdX;
    logic cmdPut;

    assign cmdStart = cmd[0];
    assign cmdA     = cmd[1];
    assign cmdX     = cmd[2];
    assign cmdPut   = cmd[3];

    // ------------------------------------------------------------------
    // FSM state and counters
    // ------------------------------------------------------------------
    stateT           state;
    stateT           stateNext;
    logic [CW-1:0]   cntA;
    logic [CW-1:0]   cntANext;
    logic [CW-1:0]   cntX;
    logic [CW-1:0]   cntXNext;
    logic [SW-1:0]   stepCnt;
    logic [SW-1:0]   stepCntNext;
    logic [PW-1:0]   pageReg;
    logic [PW-1:0]   pageNext;

    // State register together with the counters the FSM owns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cntA    <= '0;
            cntX    <= '0;
            stepCnt <= '0;
            pageReg <= '0;
        end else begin
            state   <= stateNext;
            cntA    <= cntANext;
            cntX    <= cntXNext;
            stepCnt <= stepCntNext;
            pageReg <= pageNext;
        end
    end

    // Next-state and next-counter logic.
    always_comb begin
        stateNext   = state;
        cntANext    = cntA;
        cntXNext    = cntX;
        stepCntNext = stepCnt;
        pageNext    = pageReg;
        case (state)
            IDLE: begin
                if (cmdStart) begin
                    stateNext = LOAD;
                    cntANext  = '0;
                    cntXNext  = '0;
                end
            end
            LOAD: begin
                if (cmdStart) begin
                    // Restart collection; byte commands in this cycle are dropped.
                    cntANext = '0;
                    cntXNext = '0;
                end else begin
                    if (cmdA && (cntA < nbCnt)) begin
                        cntANext = cntA + CW'(1);
                    end
                    if (cmdX && (cntX < nbCnt)) begin
                        cntXNext = cntX + CW'(1);
                    end
                    if ((cntANext == nbCnt) && (cntXNext == nbCnt)) begin
                        stateNext = INIT;
                    end
                end
            end
            INIT: begin
                stateNext   = CALC;
                stepCntNext = '0;
            end
            CALC: begin
                stepCntNext = stepCnt + SW'(1);
                if (stepCnt == stepLast) begin
                    stateNext   = DONE;
                    stepCntNext = '0;
                    pageNext    = '0;
                end
            end
            DONE: begin
                if (cmdStart) begin
                    stateNext = LOAD;
                    cntANext  = '0;
                    cntXNext  = '0;
                end else if (cmdPut) begin
                    pageNext = pageReg + PW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Datapath strobes decoded from the current state and this cycle's commands.
    always_comb begin
        ldA      = '0;
        ldX      = '0;
        initP    = 1'b0;
        shEn     = 1'b0;
        lastStep = 1'b0;
        readyAR4 = 1'b0;
        dispEn   = 1'b0;
        case (state)
            LOAD: begin
                if (!cmdStart) begin
                    if (cmdA && (cntA < nbCnt)) begin
                        ldA = NB'(1) << cntA;
                    end
                    if (cmdX && (cntX < nbCnt)) begin
                        ldX = NB'(1) << cntX;
                    end
                end
            end
            INIT: begin
                initP = 1'b1;
            end
            CALC: begin
                shEn     = 1'b1;
                lastStep = (stepCnt == stepLast);
            end
            DONE: begin
                readyAR4 = 1'b1;
                dispEn   = cmdPut & ~cmdStart;
            end
            default: begin
            end
        endcase
    end

    assign outPage  = pageReg;
    assign dbgState = state;

endmodule
